output_trainer: RTL and testbench
=================================

Name: output_trainer

Overview:
Hardware replacement for the bench-side cost/perturbation loop that drives the LSTM `network` training port. It sits after `array_prod` (the output perceptron). For each sample it:
- supplies nominal, then sign-perturbed, output weights to the perceptron;
- evaluates a hard-sigmoid squared error on each pass;
- issues the newCostFunc/costFunc handshake to `network`;
- applies the clamped perturbation update to its own output weight bank.

Parameters:
HIDDEN_SZ, 8, hidden lanes and output weights; legal range 1..16.
QN, 6, integer bits of the fixed-point format.
QM, 11, fraction bits; BITWIDTH = QN+QM+1, and 1.0 = 2^QM.
PERT_SHIFT, 9, perturbation magnitude P = 2^QM >> PERT_SHIFT (default 4 LSB).
GAIN_SHIFT, 5, cost gain as a left shift.
LFSR_SEED, 16'hACE1, non-zero seed of the sign LFSR.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
wLoad  in  1  load wLoadData into weight bank; honoured only in IDLE
wLoadData  in  BITWIDTH*HIDDEN_SZ  initial output weights, lane l at [l*BITWIDTH +: BITWIDTH]
wmax  in  BITWIDTH  positive weight clamp magnitude
target  in  1  expected binary output for the current sample
startSample  in  1  one-cycle pulse; begins a training sample
netOutValid  in  1  perceptron result strobe (dataReadyP)
netOutput  in  BITWIDTH  signed perceptron output
weightsOut  out  BITWIDTH*HIDDEN_SZ  weights driven to the perceptron
pertActive  out  1  high while weightsOut carries perturbed weights
pertSign  out  HIDDEN_SZ  sign vector of the current sample
newCostFunc  out  1  one-cycle strobe to `network`
costFunc  out  BITWIDTH  signed cost; valid while newCostFunc=1
predBit  out  1  nominal-pass prediction
wrongBit  out  1  predBit != target; valid from nominal pass to next startSample
trainDone  out  1  one-cycle pulse when the update is committed

Behaviour:
Reset (reset=0, async):
- state IDLE; weights 0; LFSR = LFSR_SEED.
- All outputs 0.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- On an accepted startSample: pertSign <= lfsr[HIDDEN_SZ-1:0] (pre-advance value), then the LFSR advances one step.

States:
- IDLE: weightsOut = W. wLoad sets W = wLoadData. On startSample go to WAIT_NOM. netOutValid is ignored.
- WAIT_NOM: weightsOut = W. On netOutValid: register Jnom, predBit = (netOutput >= 0), wrongBit; go to WAIT_PERT. From the next cycle, weightsOut lane l = sat(W[l] + P) if pertSign[l] = 1, else sat(W[l] − P); pertActive = 1.
- WAIT_PERT: on netOutValid, compute Jpert and register costFunc; go to COST.
- COST: newCostFunc = 1 for exactly this cycle; pertActive = 0. Next state UPDATE.
- UPDATE: W[l] <= clamp(W[l] − cost) if pertSign[l] = 1, else clamp(W[l] + cost). trainDone = 1 for this cycle. Return to IDLE; weightsOut shows the new W the next cycle.

Arithmetic (signed, widened internally, no overflow before saturation):
- Hard sigmoid: s = clamp((netOutput >>> 2) + 2^(QM−1), 0, 2^QM).
- Error: e = target·2^QM − s; J = (e·e) >>> QM, range 0..2^QM.
- Cost: costFunc = sat_BITWIDTH((Jpert − Jnom) <<< GAIN_SHIFT).
- clamp(x) = min(max(x, −wmax), wmax). sat = saturate to the signed BITWIDTH range.

Boundaries:
- startSample outside IDLE is ignored.
- wLoad outside IDLE is ignored.
- netOutValid in COST or UPDATE is ignored.
- startSample and wLoad in the same cycle: wLoad applies first; the sample uses the loaded W.
- Reset mid-sample: immediate return to IDLE; no newCostFunc or trainDone; W cleared.

Latency: netOutValid of the perturbed pass at cycle t gives newCostFunc at t+1 and trainDone at t+2.

Test Plan:
- Reset: assert reset=0 mid-run → all outputs 0 and weightsOut=0. After release, the first pertSign equals LFSR_SEED[7:0] = 8'hE1.
- No gradient: load W = 0x00400 (all lanes), target=1, netOutput=0 on both passes → Jnom = Jpert = 512, costFunc=0 with a one-cycle newCostFunc, W unchanged, trainDone at t+2.
- Perturbation view: after the nominal netOutValid with pertSign=8'hE1 → lanes 0, 5, 6, 7 read 0x00404, others 0x003FC, pertActive=1.
- Clamp: W = 1024, wmax = 14336, target=1, nominal netOutput=0, perturbed netOutput=4096 → costFunc = −16384. Sign-1 lanes become 14336; sign-0 lanes become −14336.
- Sigmoid saturation: netOutput = −8192, target=0 → predBit=0, wrongBit=0, J=0. netOutput = +8192, target=0 → wrongBit=1, J=2048.
- Protocol: startSample during WAIT_PERT and netOutValid in IDLE → ignored, no state change. Reset during WAIT_PERT → no newCostFunc.

Source files
------------

// File: rtl/output_trainer_if.sv
// Bundle between output_trainer and its environment: weight load, the
// perceptron result/weight path and the cost handshake towards `network`.
interface output_trainer_if #(
    parameter int HIDDEN_SZ = 8,
    parameter int BITWIDTH  = 18
);
    logic                            wLoad;
    logic [BITWIDTH*HIDDEN_SZ-1:0]   wLoadData;
    logic [BITWIDTH-1:0]             wmax;
    logic                            target;
    logic                            startSample;
    logic                            netOutValid;
    logic signed [BITWIDTH-1:0]      netOutput;
    logic [BITWIDTH*HIDDEN_SZ-1:0]   weightsOut;
    logic                            pertActive;
    logic [HIDDEN_SZ-1:0]            pertSign;
    logic                            newCostFunc;
    logic signed [BITWIDTH-1:0]      costFunc;
    logic                            predBit;
    logic                            wrongBit;
    logic                            trainDone;

    // Trainer side.
    modport master (
        input  wLoad, wLoadData, wmax, target, startSample, netOutValid, netOutput,
        output weightsOut, pertActive, pertSign, newCostFunc, costFunc, predBit, wrongBit,
               trainDone
    );

    // Environment side (perceptron, network, sequencer).
    modport slave (
        output wLoad, wLoadData, wmax, target, startSample, netOutValid, netOutput,
        input  weightsOut, pertActive, pertSign, newCostFunc, costFunc, predBit, wrongBit,
               trainDone
    );
endinterface

// File: rtl/output_trainer.sv
// Output-layer trainer: runs a nominal and a sign-perturbed perceptron pass per
// sample, turns the hard-sigmoid squared-error difference into a cost for
// `network`, and applies the clamped perturbation update to its weight bank.
module output_trainer #(
    parameter int          HIDDEN_SZ  = 8,
    parameter int          QN         = 6,
    parameter int          QM         = 11,
    parameter int          PERT_SHIFT = 9,
    parameter int          GAIN_SHIFT = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    output_trainer_if.master  bus
);
    localparam int BITWIDTH        = QN + QM + 1;
    localparam int signed ONE      = 1 << QM;
    localparam int signed HALF     = 1 << (QM - 1);
    localparam int signed PERT     = ONE >>> PERT_SHIFT;
    localparam int signed SAT_MAX  = (1 << (BITWIDTH - 1)) - 1;
    localparam int signed SAT_MIN  = -(1 << (BITWIDTH - 1));

    typedef enum logic [2:0] {StIdle, StWaitNom, StWaitPert, StCost, StUpdate} state_t;

    state_t                     state;
    logic signed [BITWIDTH-1:0] wBank [HIDDEN_SZ];
    logic [15:0]                lfsr;
    logic [HIDDEN_SZ-1:0]       pertSignQ;
    int signed                  jNom;
    logic signed [BITWIDTH-1:0] costQ;
    logic                       pertActiveQ;
    logic                       newCostQ;
    logic                       trainDoneQ;
    logic                       predQ;
    logic                       wrongQ;
    int signed                  wmaxInt;
    logic                       lfsrFb;

    function automatic logic signed [BITWIDTH-1:0] satW(input int signed x);
        if (x > SAT_MAX) return BITWIDTH'(SAT_MAX);
        if (x < SAT_MIN) return BITWIDTH'(SAT_MIN);
        return BITWIDTH'(x);
    endfunction

    function automatic int signed clampW(input int signed x, input int signed lim);
        if (x > lim)  return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    // Squared error of the hard sigmoid against the binary target, range 0..ONE.
    function automatic int signed errCost(input logic signed [BITWIDTH-1:0] y, input logic tgt);
        int signed      s;
        int signed      e;
        longint signed  sq;
        s = (int'(y) >>> 2) + HALF;
        if (s < 0)   s = 0;
        if (s > ONE) s = ONE;
        e  = (tgt ? ONE : 0) - s;
        sq = longint'(e) * longint'(e);
        return int'(sq >>> QM);
    endfunction

    assign wmaxInt = int'(bus.wmax);
    assign lfsrFb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign bus.pertActive  = pertActiveQ;
    assign bus.pertSign    = pertSignQ;
    assign bus.newCostFunc = newCostQ;
    assign bus.costFunc    = costQ;
    assign bus.predBit     = predQ;
    assign bus.wrongBit    = wrongQ;
    assign bus.trainDone   = trainDoneQ;

    // Drive the bank to the perceptron, nudged by +/-P per lane during the perturbed pass.
    always_comb begin
        bus.weightsOut = '0;
        for (int l = 0; l < HIDDEN_SZ; l++) begin
            if (pertActiveQ) begin
                bus.weightsOut[l*BITWIDTH +: BITWIDTH] =
                    satW(int'(wBank[l]) + (pertSignQ[l] ? PERT : -PERT));
            end else begin
                bus.weightsOut[l*BITWIDTH +: BITWIDTH] = wBank[l];
            end
        end
    end

    // Sample sequencer: state, weight bank, LFSR and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            lfsr        <= LFSR_SEED;
            pertSignQ   <= '0;
            jNom        <= 0;
            costQ       <= '0;
            pertActiveQ <= 1'b0;
            newCostQ    <= 1'b0;
            trainDoneQ  <= 1'b0;
            predQ       <= 1'b0;
            wrongQ      <= 1'b0;
            for (int l = 0; l < HIDDEN_SZ; l++) wBank[l] <= '0;
        end else begin
            newCostQ   <= 1'b0;
            trainDoneQ <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A load in the same cycle as startSample lands before the nominal pass.
                    if (bus.wLoad) begin
                        for (int l = 0; l < HIDDEN_SZ; l++) begin
                            wBank[l] <= bus.wLoadData[l*BITWIDTH +: BITWIDTH];
                        end
                    end
                    if (bus.startSample) begin
                        pertSignQ <= lfsr[HIDDEN_SZ-1:0];
                        lfsr      <= {lfsrFb, lfsr[15:1]};
                        state     <= StWaitNom;
                    end
                end
                StWaitNom: begin
                    if (bus.netOutValid) begin
                        jNom        <= errCost(bus.netOutput, bus.target);
                        predQ       <= ~bus.netOutput[BITWIDTH-1];
                        wrongQ      <= ~bus.netOutput[BITWIDTH-1] ^ bus.target;
                        pertActiveQ <= 1'b1;
                        state       <= StWaitPert;
                    end
                end
                StWaitPert: begin
                    if (bus.netOutValid) begin
                        costQ <= satW((errCost(bus.netOutput, bus.target) - jNom) <<< GAIN_SHIFT);
                        newCostQ    <= 1'b1;
                        pertActiveQ <= 1'b0;
                        state       <= StCost;
                    end
                end
                StCost: begin
                    trainDoneQ <= 1'b1;
                    state      <= StUpdate;
                end
                StUpdate: begin
                    // Step each lane against its perturbation sign, scaled by the cost.
                    for (int l = 0; l < HIDDEN_SZ; l++) begin
                        wBank[l] <= BITWIDTH'(clampW(int'(wBank[l]) +
                            (pertSignQ[l] ? -int'(costQ) : int'(costQ)), wmaxInt));
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_output_trainer.sv
// Directed bench for output_trainer: expected costs are queued when the
// perturbed result is driven and checked when newCostFunc appears.
module tb_output_trainer;
    localparam int HS = 8;
    localparam int BW = 18;
    localparam int WMAX = 14336;

    logic clock = 1'b0;
    logic reset = 1'b0;

    output_trainer_if #(.HIDDEN_SZ(HS), .BITWIDTH(BW)) bus ();

    output_trainer #(.HIDDEN_SZ(HS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          nAsserts = 0;
    int          nFails   = 0;
    int          expQ[$];
    int          wModel[HS];
    logic [15:0] lfsrModel = 16'hACE1;
    logic [HS-1:0] signModel;
    logic        predModel;
    logic        wrongModel;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    function automatic int clampInt(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    // Hard sigmoid in Q6.11, then squared error scaled back to Q.11.
    function automatic int jOf(input int y, input bit tgt);
        int s;
        int e;
        s = clampInt((y >>> 2) + 1024, 0, 2048);
        e = (tgt ? 2048 : 0) - s;
        return (e * e) / 2048;
    endfunction

    function automatic logic [BW*HS-1:0] packW(input bit pert);
        logic [BW*HS-1:0] r;
        int v;
        for (int l = 0; l < HS; l++) begin
            v = wModel[l];
            if (pert) v = clampInt(v + (signModel[l] ? 4 : -4), -131072, 131071);
            r[l*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Any newCostFunc must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.newCostFunc === 1'b1) begin
            if (expQ.size() == 0) chk("cost_unexpected", bus.newCostFunc, 1'b0);
            else chk("costFunc", bus.costFunc, BW'(expQ.pop_front()));
        end
    end

    task automatic checkAllZero(input string tag);
        chk({tag, "_weights"}, bus.weightsOut, '0);
        chk({tag, "_flags"}, {bus.pertActive, bus.newCostFunc, bus.predBit, bus.wrongBit,
                              bus.trainDone}, 5'b0);
        chk({tag, "_sign"}, bus.pertSign, '0);
        chk({tag, "_cost"}, bus.costFunc, '0);
    endtask

    task automatic runSample(input bit doLoad, input int loadVal, input int nom, input int pert,
                             input bit tgt, input bit poke);
        int jn;
        int c;
        bus.target      = tgt;
        bus.startSample = 1'b1;
        if (doLoad) begin
            bus.wLoad = 1'b1;
            for (int l = 0; l < HS; l++) bus.wLoadData[l*BW +: BW] = BW'(loadVal);
            for (int l = 0; l < HS; l++) wModel[l] = loadVal;
        end
        step();
        bus.startSample = 1'b0;
        bus.wLoad       = 1'b0;
        signModel = lfsrModel[HS-1:0];
        lfsrModel = lfsrNext(lfsrModel);
        chk("pertSign", bus.pertSign, signModel);
        chk("weights_nom", bus.weightsOut, packW(1'b0));
        chk("pertActive_nom", bus.pertActive, 1'b0);
        step();

        bus.netOutValid = 1'b1;
        bus.netOutput   = BW'(nom);
        step();
        bus.netOutValid = 1'b0;
        jn         = jOf(nom, tgt);
        predModel  = (nom >= 0);
        wrongModel = (predModel != tgt);
        chk("predBit", bus.predBit, predModel);
        chk("wrongBit", bus.wrongBit, wrongModel);
        chk("pertActive_pert", bus.pertActive, 1'b1);
        chk("weights_pert", bus.weightsOut, packW(1'b1));

        if (poke) begin
            bus.startSample = 1'b1;
            bus.wLoad       = 1'b1;
            bus.wLoadData   = '1;
            step();
            bus.startSample = 1'b0;
            bus.wLoad       = 1'b0;
            chk("poke_sign", bus.pertSign, signModel);
            chk("poke_active", bus.pertActive, 1'b1);
            chk("poke_weights", bus.weightsOut, packW(1'b1));
        end

        c = clampInt((jOf(pert, tgt) - jn) * 32, -131072, 131071);
        expQ.push_back(c);
        bus.netOutValid = 1'b1;
        bus.netOutput   = BW'(pert);
        step();
        // A strobe during COST must be ignored.
        bus.netOutput = BW'(poke ? 8192 : pert);
        chk("newCost_t1", bus.newCostFunc, 1'b1);
        chk("pertActive_cost", bus.pertActive, 1'b0);
        chk("trainDone_t1", bus.trainDone, 1'b0);
        step();
        bus.netOutValid = 1'b0;
        chk("newCost_t2", bus.newCostFunc, 1'b0);
        chk("trainDone_t2", bus.trainDone, 1'b1);
        for (int l = 0; l < HS; l++) begin
            wModel[l] = clampInt(wModel[l] + (signModel[l] ? -c : c), -WMAX, WMAX);
        end
        step();
        chk("trainDone_t3", bus.trainDone, 1'b0);
        chk("weights_updated", bus.weightsOut, packW(1'b0));
    endtask

    initial begin
        bus.wLoad       = 1'b0;
        bus.wLoadData   = '0;
        bus.wmax        = BW'(WMAX);
        bus.target      = 1'b0;
        bus.startSample = 1'b0;
        bus.netOutValid = 1'b0;
        bus.netOutput   = '0;
        for (int l = 0; l < HS; l++) wModel[l] = 0;
        repeat (3) step();
        checkAllZero("reset");
        reset = 1'b1;
        step();

        // No gradient, load coinciding with start.
        runSample(1'b1, 32'h400, 0, 0, 1'b1, 1'b0);
        // Clamp case, with start/load pokes during the perturbed wait.
        runSample(1'b1, 1024, 0, 4096, 1'b1, 1'b1);
        // Sigmoid saturation low and high.
        runSample(1'b0, 0, -8192, -8192, 1'b0, 1'b0);
        runSample(1'b0, 0, 8192, 0, 1'b0, 1'b0);

        // Strobe while idle is ignored.
        bus.netOutValid = 1'b1;
        bus.netOutput   = BW'(-8192);
        step();
        bus.netOutValid = 1'b0;
        chk("idle_active", bus.pertActive, 1'b0);
        chk("idle_pred", {bus.predBit, bus.wrongBit}, {predModel, wrongModel});
        runSample(1'b0, 0, 100, -100, 1'b1, 1'b0);

        // Reset during the perturbed wait.
        bus.target      = 1'b1;
        bus.startSample = 1'b1;
        step();
        bus.startSample = 1'b0;
        bus.netOutValid = 1'b1;
        bus.netOutput   = '0;
        step();
        bus.netOutValid = 1'b0;
        chk("pre_reset_active", bus.pertActive, 1'b1);
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (3) step();
        reset = 1'b1;
        lfsrModel = 16'hACE1;
        for (int l = 0; l < HS; l++) wModel[l] = 0;
        step();
        runSample(1'b0, 0, 0, 2048, 1'b1, 1'b0);

        repeat (3) step();
        chk("queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
